// File: rtl/hazard_unit.sv
// hazard_unit: stall and operand-forwarding control, driven by shadow E/M/W slots
// that track which register each in-flight instruction writes and when its value exists.
module hazard_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [2:0]  D_Tuse_rs,
    input  logic [2:0]  D_Tuse_rt,
    input  logic [4:0]  D_A3,
    input  logic [2:0]  D_Tnew,
    output logic        stall,
    output logic [1:0]  D_fwd_rs,
    output logic [1:0]  D_fwd_rt,
    output logic [1:0]  E_fwd_rs,
    output logic [1:0]  E_fwd_rt,
    output logic [15:0] stall_cnt
);
    typedef struct packed {
        logic [4:0] a3;
        logic [2:0] tnew;
    } prod_t;

    // M and W only keep the fields anything downstream still reads
    logic [4:0] e_rs, e_rt, w_a3;
    prod_t      e, m;

    function automatic prod_t age(input prod_t p);
        age      = p;
        age.tnew = p.tnew == 3'd0 ? 3'd0 : p.tnew - 3'd1;
    endfunction

    function automatic logic hit(input logic [4:0] r, input logic [2:0] tuse, input prod_t p);
        hit = r != 5'd0 && p.a3 == r && p.tnew > tuse;
    endfunction

    function automatic logic [1:0] d_sel(input logic [4:0] r, input prod_t pe, input prod_t pm,
                                         input logic [4:0] wa);
        d_sel = r == 5'd0                        ? 2'd0 :
                (pe.a3 == r && pe.tnew == 3'd0) ? 2'd1 :
                (pm.a3 == r && pm.tnew == 3'd0) ? 2'd2 :
                wa == r                          ? 2'd3 : 2'd0;
    endfunction

    function automatic logic [1:0] e_sel(input logic [4:0] r, input prod_t pm, input logic [4:0] wa);
        e_sel = r == 5'd0                        ? 2'd0 :
                (pm.a3 == r && pm.tnew == 3'd0) ? 2'd1 :
                wa == r                          ? 2'd2 : 2'd0;
    endfunction

    // reset gates everything so a stall drops without waiting for the slots to clear
    assign stall    = !reset && (hit(D_rs, D_Tuse_rs, e) || hit(D_rs, D_Tuse_rs, m) ||
                                 hit(D_rt, D_Tuse_rt, e) || hit(D_rt, D_Tuse_rt, m));
    assign D_fwd_rs = reset ? 2'd0 : d_sel(D_rs, e, m, w_a3);
    assign D_fwd_rt = reset ? 2'd0 : d_sel(D_rt, e, m, w_a3);
    assign E_fwd_rs = reset ? 2'd0 : e_sel(e_rs, m, w_a3);
    assign E_fwd_rt = reset ? 2'd0 : e_sel(e_rt, m, w_a3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_rs      <= '0;
            e_rt      <= '0;
            e         <= '0;
            m         <= '0;
            w_a3      <= '0;
            stall_cnt <= '0;
        end else begin
            e_rs      <= stall ? 5'd0 : D_rs;
            e_rt      <= stall ? 5'd0 : D_rt;
            e         <= stall ? '0 : {D_A3, D_Tnew};
            m         <= age(e);
            w_a3      <= m.a3;
            if (stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL provide port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL provide port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL provide port: D_rs  input  5  rs field of the instruction in D.
REQ-004 SHALL provide port: D_rt  input  5  rt field of the instruction in D.
REQ-005 SHALL provide port: D_Tuse_rs  input  3  cycles until D instruction needs rs; 3 = unused.
REQ-006 SHALL provide port: D_Tuse_rt  input  3  same for rt; 3 = unused.
REQ-007 SHALL provide port: D_A3  input  5  destination register of D instruction, already resolved from WRsel; 0 if RFWr=0.
REQ-008 SHALL provide port: D_Tnew  input  3  cycles after entering E until the result exists (lw=2, alu/lui=1, jal=0).
REQ-009 SHALL provide port: stall  output  1  freeze PC and F/D; insert bubble into D/E.
REQ-010 SHALL provide port: D_fwd_rs, D_fwd_rt  output  2 each  D-stage operand source: 0=RF, 1=E, 2=M, 3=W.
REQ-011 SHALL provide port: E_fwd_rs, E_fwd_rt  output  2 each  E-stage operand source: 0=pipeline register, 1=M, 2=W.
REQ-012 SHALL provide port: stall_cnt  output  16  count of stall cycles since reset.

Function
REQ-013 SHALL hold three shadow slots E, M and W; each slot holds rs[4:0], rt[4:0], A3[4:0] and Tnew[2:0].
REQ-014 On each clock edge with stall=0, slot E SHALL load {D_rs, D_rt, D_A3, D_Tnew}.
REQ-015 On each clock edge with stall=1, slot E SHALL load a bubble, all fields 0.
REQ-016 On every clock edge, M SHALL load from E and W SHALL load from M, regardless of stall.
REQ-017 When advancing, Tnew SHALL decrement by 1, saturating at 0 (never wraps to 7).
REQ-018 Stall condition for rs: D_rs!=0, and a slot X in {E, M} has X.A3==D_rs and X.Tnew > D_Tuse_rs.
REQ-019 Stall condition for rt is the same as REQ-018, using D_rt and D_Tuse_rt.
REQ-020 stall SHALL be combinational and equal the OR of the rs and rt stall conditions.
REQ-021 Slot W SHALL never cause a stall.
REQ-022 Tuse=3 SHALL never cause a stall, because Tnew never exceeds 2.
REQ-023 D_fwd_rs is combinational, first match wins: E.A3==D_rs && E.Tnew==0 -> 1.
REQ-024 D_fwd_rs, second priority: M.A3==D_rs && M.Tnew==0 -> 2.
REQ-025 D_fwd_rs, third priority: W.A3==D_rs -> 3; otherwise 0.
REQ-026 All matches in REQ-023 to REQ-025 require D_rs!=0; D_fwd_rt follows the same rules using D_rt.
REQ-027 E_fwd_rs is combinational: M.A3==E.rs && M.Tnew==0 -> 1; else W.A3==E.rs -> 2; else 0.
REQ-028 All matches in REQ-027 require E.rs!=0; E_fwd_rt follows the same rules using E.rt.
REQ-029 The youngest producer SHALL always win when several slots target the same register.
REQ-030 Register 0 SHALL never stall and never forward.
REQ-031 stall_cnt SHALL increment by 1 on each clock edge where stall=1, saturating at 16'hFFFF.
REQ-032 A stall SHALL last the minimum number of cycles needed: lw followed by a dependent beq stalls 2 cycles, and by a dependent add stalls 1 cycle.

Reset
REQ-033 While reset=1, all slot fields and stall_cnt SHALL be 0.
REQ-034 While reset=1, outputs SHALL be stall=0 and all fwd selects 0.
REQ-035 Reset asserted mid-stall SHALL drop stall in the same cycle, without waiting for a clock edge.
REQ-036 The first edge after reset is released SHALL load slot E normally from the D inputs.

Verification
REQ-037 Directed test, lw then dependent add: lw $1 (D_A3=1, Tnew=2) then add rs=1 (Tuse_rs=1) -> stall=1 for exactly 1 cycle, stall_cnt=1; next cycle D_fwd_rs=0 and E_fwd_rs=1 once lw reaches M... see REQ-038 for the exact timing.
REQ-038 Directed test, timing of REQ-037: after the bubble, add reaches E while lw is in W, so E_fwd_rs=2.
REQ-039 Directed test, lw then dependent beq: lw $2 then beq rs=2 (Tuse=0) -> stall 2 cycles, then D_fwd_rs=3, stall_cnt=2.
REQ-040 Directed test, ALU back-to-back: ori $3 (Tnew=1) then beq rt=3 -> stall 1 cycle, then D_fwd_rt=2.
REQ-041 Directed test, ALU back-to-back: ori $3 then add rt=3 -> no stall, and E_fwd_rt=1 in the following cycle.
REQ-042 Directed test, jal then jr: jal (A3=31, Tnew=0) then jr rs=31 (Tuse=0) -> no stall, D_fwd_rs=1.
REQ-043 Directed test, $0 and priority: writes to $0 with Tnew=2 followed by a reader of $0 -> no stall, fwd=0.
REQ-044 Directed test, $0 and priority: E and M both target $5 with Tnew=0 -> D_fwd_rs=1.
REQ-045 Directed test, reset during stall: assert reset during a lw-use stall -> stall falls immediately and stall_cnt=0.
REQ-046 Directed test, counter saturation: force 65540 stall cycles -> stall_cnt holds 16'hFFFF.
